// File: rtl/hmac_seq_core_if.sv
// Signal bundle shared by the HMAC register front-end, the sequencer and the single hash engine.
// The slave modport is the sequencer; the master modport is everything around it.
interface hmac_seq_core_if #(
   parameter int BLOCK_W  = 1024,
   parameter int DIGEST_W = 512
);
   logic                 init_cmd;
   logic                 next_cmd;
   logic                 last_cmd;
   logic                 mode_cmd;
   logic [BLOCK_W/2-1:0] key;
   logic [BLOCK_W-1:0]   block_msg;
   logic                 ready;
   logic                 tag_valid;
   logic [DIGEST_W-1:0]  tag;
   logic                 hash_init;
   logic                 hash_next;
   logic [1:0]           hash_mode;
   logic [BLOCK_W-1:0]   hash_block;
   logic                 hash_ready;
   logic [DIGEST_W-1:0]  hash_digest;

   modport master (
      output init_cmd, next_cmd, last_cmd, mode_cmd, key, block_msg, hash_ready, hash_digest,
      input  ready, tag_valid, tag, hash_init, hash_next, hash_mode, hash_block
   );

   modport slave (
      input  init_cmd, next_cmd, last_cmd, mode_cmd, key, block_msg, hash_ready, hash_digest,
      output ready, tag_valid, tag, hash_init, hash_next, hash_mode, hash_block
   );
endinterface

// File: rtl/hmac_seq_core.sv
// HMAC sequencer: runs inner and outer hashes back to back on one shared SHA-2 engine,
// accepting any number of caller-padded message blocks per tag.
module hmac_seq_core #(
   parameter int BLOCK_W  = 1024,
   parameter int DIGEST_W = 512,
   parameter int TRUNC_W  = 384,
   parameter int LEN_W    = 128
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           zeroize,
   hmac_seq_core_if.slave bus
);

   localparam logic [LEN_W-1:0]   LEN_FULL  = LEN_W'(BLOCK_W + DIGEST_W);
   localparam logic [LEN_W-1:0]   LEN_TRUNC = LEN_W'(BLOCK_W + TRUNC_W);
   localparam logic [BLOCK_W-1:0] IPAD_PAT  = {(BLOCK_W/8){8'h36}};
   localparam logic [BLOCK_W-1:0] OPAD_PAT  = {(BLOCK_W/8){8'h5c}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_IPAD  = 3'd1,
      S_MSG   = 3'd2,
      S_OPAD  = 3'd3,
      S_OUTER = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e              state_q;
   logic                entry_q;
   logic                chain_open_q;
   logic                last_q;
   logic                mode_q;
   logic                ready_q;
   logic                tag_valid_q;
   logic                hash_init_q;
   logic                hash_next_q;
   logic [DIGEST_W-1:0] inner_q;
   logic [DIGEST_W-1:0] tag_q;

   logic                leave_s;
   logic [BLOCK_W-1:0]  key_ext_s;
   logic [BLOCK_W-1:0]  pad_blk_s;
   logic [BLOCK_W-1:0]  hash_block_s;
   logic [DIGEST_W-1:0] trunc_dig_s;

   // The entry cycle of every hash state ignores hash_ready, which may still be high from the last block.
   assign leave_s   = !entry_q && bus.hash_ready;
   assign key_ext_s = {bus.key, {(BLOCK_W/2){1'b0}}};

   // Outer-hash input block and truncated final digest, both shaped by the latched mode.
   always_comb begin
      if (mode_q) begin
         pad_blk_s   = {inner_q, 1'b1, {(BLOCK_W-DIGEST_W-1-LEN_W){1'b0}}, LEN_FULL};
         trunc_dig_s = bus.hash_digest;
      end else begin
         pad_blk_s   = {inner_q[DIGEST_W-1 -: TRUNC_W], 1'b1,
                        {(BLOCK_W-TRUNC_W-1-LEN_W){1'b0}}, LEN_TRUNC};
         trunc_dig_s = {bus.hash_digest[DIGEST_W-1 -: TRUNC_W], {(DIGEST_W-TRUNC_W){1'b0}}};
      end
   end

   // Block presented to the hash engine in each state.
   always_comb begin
      hash_block_s = '0;
      case (state_q)
         S_IPAD:  hash_block_s = key_ext_s ^ IPAD_PAT;
         S_MSG:   hash_block_s = bus.block_msg;
         S_OPAD:  hash_block_s = key_ext_s ^ OPAD_PAT;
         S_OUTER: hash_block_s = pad_blk_s;
         default: hash_block_s = '0;
      endcase
   end

   // Sequencer FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         entry_q      <= 1'b0;
         chain_open_q <= 1'b0;
         last_q       <= 1'b0;
         mode_q       <= 1'b0;
         ready_q      <= 1'b1;
         tag_valid_q  <= 1'b0;
         hash_init_q  <= 1'b0;
         hash_next_q  <= 1'b0;
         inner_q      <= '0;
         tag_q        <= '0;
      end else if (zeroize) begin
         state_q      <= S_IDLE;
         entry_q      <= 1'b0;
         chain_open_q <= 1'b0;
         last_q       <= 1'b0;
         mode_q       <= 1'b0;
         ready_q      <= 1'b1;
         tag_valid_q  <= 1'b0;
         hash_init_q  <= 1'b0;
         hash_next_q  <= 1'b0;
         inner_q      <= '0;
         tag_q        <= '0;
      end else begin
         hash_init_q <= 1'b0;
         hash_next_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.init_cmd) begin
                  mode_q       <= bus.mode_cmd;
                  last_q       <= bus.last_cmd;
                  chain_open_q <= 1'b1;
                  tag_valid_q  <= 1'b0;
                  tag_q        <= '0;
                  ready_q      <= 1'b0;
                  entry_q      <= 1'b1;
                  hash_init_q  <= 1'b1;
                  state_q      <= S_IPAD;
               end else if (bus.next_cmd && chain_open_q) begin
                  last_q      <= bus.last_cmd;
                  tag_valid_q <= 1'b0;
                  tag_q       <= '0;
                  ready_q     <= 1'b0;
                  entry_q     <= 1'b1;
                  hash_next_q <= 1'b1;
                  state_q     <= S_MSG;
               end
            end
            S_IPAD: begin
               entry_q <= 1'b0;
               if (leave_s) begin
                  entry_q     <= 1'b1;
                  hash_next_q <= 1'b1;
                  state_q     <= S_MSG;
               end
            end
            S_MSG: begin
               entry_q <= 1'b0;
               if (leave_s && last_q) begin
                  inner_q     <= bus.hash_digest;
                  entry_q     <= 1'b1;
                  hash_init_q <= 1'b1;
                  state_q     <= S_OPAD;
               end else if (leave_s) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            S_OPAD: begin
               entry_q <= 1'b0;
               if (leave_s) begin
                  entry_q     <= 1'b1;
                  hash_next_q <= 1'b1;
                  state_q     <= S_OUTER;
               end
            end
            S_OUTER: begin
               entry_q <= 1'b0;
               // The inner digest is spent by now, so it parks the truncated tag until DONE.
               if (leave_s) begin
                  inner_q      <= trunc_dig_s;
                  chain_open_q <= 1'b0;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: begin
               tag_q       <= inner_q;
               tag_valid_q <= 1'b1;
               ready_q     <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.tag_valid  = tag_valid_q;
   assign bus.tag        = tag_q;
   assign bus.hash_init  = hash_init_q;
   assign bus.hash_next  = hash_next_q;
   assign bus.hash_mode  = {1'b1, mode_q};
   assign bus.hash_block = hash_block_s;

endmodule

// File: tb/tb_hmac_seq_core.sv
// Bench for hmac_seq_core: a toy hash engine with programmable latency stands in for SHA-2,
// and a reference model builds the expected HMAC tag from the same toy compression.
module tb_hmac_seq_core;
   localparam int BW = 1024;
   localparam int DW = 512;
   localparam int TW = 384;
   localparam int LW = 128;
   localparam logic [DW-1:0] IV = {8{64'h6a09e667f3bcc908}};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic zeroize = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lh = 3;

   hmac_seq_core_if #(.BLOCK_W(BW), .DIGEST_W(DW)) bus();

   hmac_seq_core #(.BLOCK_W(BW), .DIGEST_W(DW), .TRUNC_W(TW), .LEN_W(LW)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .zeroize(zeroize),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] toy(input logic [DW-1:0] s, input logic [BW-1:0] b);
      return {s[DW-2:0], s[DW-1]} ^ b[BW-1:DW] ^ (b[DW-1:0] + s);
   endfunction

   // mock hash engine: ready drops the cycle after a command and returns lh cycles after it
   logic          mk_ready;
   logic [DW-1:0] mk_st;
   int            mk_cnt;
   assign bus.hash_ready  = mk_ready;
   assign bus.hash_digest = mk_st;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mk_ready <= 1'b1; mk_st <= '0; mk_cnt <= 0;
      end else if (zeroize) begin
         mk_ready <= 1'b1; mk_st <= '0; mk_cnt <= 0;
      end else if (bus.hash_init) begin
         mk_st <= toy(IV, bus.hash_block); mk_ready <= 1'b0; mk_cnt <= lh - 2;
      end else if (bus.hash_next) begin
         mk_st <= toy(mk_st, bus.hash_block); mk_ready <= 1'b0; mk_cnt <= lh - 2;
      end else if (!mk_ready) begin
         if (mk_cnt == 0) mk_ready <= 1'b1;
         else mk_cnt <= mk_cnt - 1;
      end
   end

   // command monitor
   int            n_init = 0;
   int            n_next = 0;
   int            n_cmd = 0;
   int            cmd_cyc [64];
   logic [BW-1:0] last_next_blk = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.hash_init) n_init <= n_init + 1;
      if (bus.hash_next) begin
         n_next <= n_next + 1;
         last_next_blk <= bus.hash_block;
      end
      if (bus.hash_init || bus.hash_next) begin
         cmd_cyc[n_cmd % 64] <= cyc;
         n_cmd <= n_cmd + 1;
      end
   end

   logic [BW-1:0]   msgs [4];
   logic [BW/2-1:0] key_v;

   task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rnd_blk();
      logic [BW-1:0] v;
      for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic new_data(input int nblk);
      logic [BW-1:0] t;
      t = rnd_blk();
      key_v = t[BW-1:BW/2];
      for (int i = 0; i < nblk; i++) msgs[i] = rnd_blk();
      bus.key = key_v;
   endtask

   // HMAC over the toy hash: H((K^opad) || pad(trunc(H((K^ipad) || msgs))))
   task automatic ref_hmac(input int nblk, input bit mode,
                           output logic [DW-1:0] tag_e, output logic [BW-1:0] pad_e);
      int            l;
      logic [DW-1:0] s;
      logic [BW-1:0] kx;
      l  = mode ? DW : TW;
      kx = {key_v, {(BW/2){1'b0}}};
      s  = toy(IV, kx ^ {(BW/8){8'h36}});
      for (int i = 0; i < nblk; i++) s = toy(s, msgs[i]);
      s     = s >> (DW - l);
      pad_e = (BW'(s) << (BW - l)) | (BW'(1) << (BW - 1 - l)) | BW'(BW + l);
      s     = toy(toy(IV, kx ^ {(BW/8){8'h5c}}), pad_e);
      tag_e = (s >> (DW - l)) << (DW - l);
   endtask

   task automatic send(input bit init, input bit next, input bit last, input bit mode, output int acc);
      @(negedge clk);
      bus.init_cmd = init; bus.next_cmd = next; bus.last_cmd = last; bus.mode_cmd = mode;
      @(negedge clk);
      acc = cyc - 1;
      bus.init_cmd = 1'b0; bus.next_cmd = 1'b0; bus.last_cmd = 1'b0; bus.mode_cmd = 1'b0;
   endtask

   task automatic wait_ready(output int low);
      low = 0;
      while (bus.ready !== 1'b1 && low < 400) begin
         low++;
         @(negedge clk);
      end
      check("ready_timeout", DW'(low < 400), DW'(1));
   endtask

   task automatic run_hmac(input int nblk, input bit mode, input bit both, output logic [BW-1:0] pad_o);
      logic [DW-1:0] tag_e;
      int            acc, low;
      new_data(nblk);
      for (int i = 0; i < nblk; i++) begin
         bus.block_msg = msgs[i];
         send(i == 0, (i != 0) || both, i == nblk - 1, mode, acc);
         wait_ready(low);
         if (i != nblk - 1) begin
            check("tag_valid_chain_open", DW'(bus.tag_valid), DW'(0));
            check("tag_chain_open", bus.tag, '0);
         end
      end
      ref_hmac(nblk, mode, tag_e, pad_o);
      check("tag_valid_done", DW'(bus.tag_valid), DW'(1));
      check("tag", bus.tag, tag_e);
      check("hash_mode", DW'(bus.hash_mode), DW'({1'b1, mode}));
   endtask

   initial begin
      int            acc, low, base, ni0, nn0, nc, cnt;
      logic [DW-1:0] tag_e;
      logic [BW-1:0] pad_e;
      bus.init_cmd = 1'b0; bus.next_cmd = 1'b0; bus.last_cmd = 1'b0; bus.mode_cmd = 1'b0;
      bus.key = '0; bus.block_msg = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // reset state and quiet idle
      check("rst_ready", DW'(bus.ready), DW'(1));
      check("rst_tag_valid", DW'(bus.tag_valid), DW'(0));
      check("rst_tag", bus.tag, '0);
      check("rst_hash_mode", DW'(bus.hash_mode), DW'(2'b10));
      nc = n_cmd;
      repeat (100) @(negedge clk);
      check("idle_no_pulses", DW'(n_cmd - nc), DW'(0));

      // next_cmd with no open chain is ignored
      nc = n_cmd;
      send(1'b0, 1'b1, 1'b1, 1'b1, acc);
      repeat (10) @(negedge clk);
      check("next_before_init_pulses", DW'(n_cmd - nc), DW'(0));
      check("next_before_init_ready", DW'(bus.ready), DW'(1));

      // Lh=3, init and next together, single last block, full tag: timing checks
      lh = 3;
      base = n_cmd; ni0 = n_init; nn0 = n_next;
      new_data(1);
      bus.block_msg = msgs[0];
      send(1'b1, 1'b1, 1'b1, 1'b1, acc);
      wait_ready(low);
      check("ready_low_cycles", DW'(low), DW'(17));
      for (int k = 0; k < 4; k++) check("cmd_cycle", DW'(cmd_cyc[(base + k) % 64] - acc), DW'(1 + 4*k));
      check("init_pulses", DW'(n_init - ni0), DW'(2));
      check("next_pulses", DW'(n_next - nn0), DW'(2));
      ref_hmac(1, 1'b1, tag_e, pad_e);
      check("tag_full_lh3", bus.tag, tag_e);
      check("tag_valid_lh3", DW'(bus.tag_valid), DW'(1));

      // truncated tag: outer block carries length 0x580
      lh = 2;
      run_hmac(1, 1'b0, 1'b0, pad_e);
      check("outer_len_field", DW'(last_next_blk[LW-1:0]), DW'(128'h580));
      check("outer_blk_hi", last_next_blk[BW-1:DW], pad_e[BW-1:DW]);
      check("outer_blk_lo", last_next_blk[DW-1:0], pad_e[DW-1:0]);

      // two-block chain, then randomized chains
      lh = 4;
      run_hmac(2, 1'b1, 1'b0, pad_e);
      for (int r = 0; r < 4; r++) begin
         lh = $urandom_range(2, 5);
         run_hmac($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0, pad_e);
      end

      // zeroize while the outer key block is being hashed
      lh = 4;
      new_data(1);
      bus.block_msg = msgs[0];
      ni0 = n_init;
      send(1'b1, 1'b0, 1'b1, 1'b1, acc);
      cnt = 0;
      while (n_init - ni0 < 2 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("reach_opad", DW'(cnt < 200), DW'(1));
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check("zeroize_ready", DW'(bus.ready), DW'(1));
      check("zeroize_tag", bus.tag, '0);
      check("zeroize_tag_valid", DW'(bus.tag_valid), DW'(0));
      nc = n_cmd;
      repeat (20) @(negedge clk);
      check("zeroize_no_pulses", DW'(n_cmd - nc), DW'(0));
      send(1'b0, 1'b1, 1'b1, 1'b1, acc);
      repeat (10) @(negedge clk);
      check("next_after_zeroize_pulses", DW'(n_cmd - nc), DW'(0));
      check("next_after_zeroize_ready", DW'(bus.ready), DW'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
